// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - stopwatch run-control sequencer (debounce, tick edge, start/stop/lap/clear FSM)
//
// Optional feature macro: STOPWATCH_LAP_EN (lap button path and display_hold toggling).
// When it is undefined, btn_lap is ignored and display_hold is tied to 0.
//
// Ports:
//   clk_in          1 MHz system clock
//   res             asynchronous active-low reset
//   btn_start_stop  raw start/stop button, active-high, asynchronous
//   btn_lap         raw lap button, active-high, asynchronous
//   btn_clear       raw clear button, active-high, asynchronous
//   tick_in         100 Hz square wave from the clock divider
//   div_res         active-low reset to the clock divider (low only while CLEARED)
//   count_en        one-cycle enable to the time counters per tick while RUNNING
//   count_clr       one-cycle clear to the time counters on STOPPED -> CLEARED
//   display_hold    display latch freeze (lap)
//   state           00 CLEARED, 01 RUNNING, 10 STOPPED

// Per-button synchronizer, debouncer and rising-edge press detector.
module stopwatch_debounce #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int DB_WIDTH        = 14
) (
    input  logic clk_in,
    input  logic res,
    input  logic raw,
    output logic press
);
    logic                sync_1;
    logic                sync_2;
    logic                level;
    logic                level_d;
    logic [DB_WIDTH-1:0] cnt;

    always_ff @(posedge clk_in or negedge res) begin
        if (!res) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= raw;
            sync_2  <= sync_1;
            level_d <= level;
            // Count consecutive cycles that disagree with the accepted level;
            // any agreement restarts the count.
            if (sync_2 != level) begin
                if (cnt == DB_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync_2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Releases produce nothing; a held button yields a single pulse.
    assign press = level & ~level_d;
endmodule

module stopwatch_controller #(
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int DB_WIDTH        = 14
) (
    input  logic       clk_in,
    input  logic       res,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic       tick_in,
    output logic       div_res,
    output logic       count_en,
    output logic       count_clr,
    output logic       display_hold,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        CLEARED = 2'b00,
        RUNNING = 2'b01,
        STOPPED = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t state_q;
    logic   ss_ev;
    logic   clr_ev;
    logic   tick_r;
    logic   tick_d;
    logic   tick_ev;
    logic   div_res_q;
    logic   count_en_q;
    logic   count_clr_q;

    stopwatch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_WIDTH       (DB_WIDTH)
    ) u_db_start_stop (
        .clk_in(clk_in),
        .res   (res),
        .raw   (btn_start_stop),
        .press (ss_ev)
    );

    stopwatch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_WIDTH       (DB_WIDTH)
    ) u_db_clear (
        .clk_in(clk_in),
        .res   (res),
        .raw   (btn_clear),
        .press (clr_ev)
    );

`ifdef STOPWATCH_LAP_EN
    logic lap_ev;
    logic hold_q;

    stopwatch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DB_WIDTH       (DB_WIDTH)
    ) u_db_lap (
        .clk_in(clk_in),
        .res   (res),
        .raw   (btn_lap),
        .press (lap_ev)
    );

    assign display_hold = hold_q;
`else
    logic unused_lap;
    assign unused_lap   = btn_lap;
    assign display_hold = 1'b0;
`endif

    // The divider output is registered once; its falling edge marks one full
    // 10 ms period, so the first event arrives a whole period after div_res releases.
    always_ff @(posedge clk_in or negedge res) begin
        if (!res) begin
            tick_r <= 1'b0;
            tick_d <= 1'b0;
        end else begin
            tick_r <= tick_in;
            tick_d <= tick_r;
        end
    end

    assign tick_ev = tick_d & ~tick_r;

    always_ff @(posedge clk_in or negedge res) begin
        if (!res) begin
            state_q     <= CLEARED;
            div_res_q   <= 1'b0;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            hold_q      <= 1'b0;
`endif
        end else begin
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            case (state_q)
                CLEARED: begin
                    div_res_q <= 1'b0;
                    if (ss_ev) begin
                        state_q   <= RUNNING;
                        div_res_q <= 1'b1;
                    end
                end
                RUNNING: begin
                    div_res_q <= 1'b1;
                    // A tick coinciding with the stop press still counts.
                    if (tick_ev) begin
                        count_en_q <= 1'b1;
                    end
                    if (ss_ev) begin
                        state_q <= STOPPED;
                    end
`ifdef STOPWATCH_LAP_EN
                    else if (lap_ev) begin
                        hold_q <= ~hold_q;
                    end
`endif
                end
                STOPPED: begin
                    div_res_q <= 1'b1;
                    if (ss_ev) begin
                        state_q <= RUNNING;
                    end else if (clr_ev) begin
                        state_q     <= CLEARED;
                        div_res_q   <= 1'b0;
                        count_clr_q <= 1'b1;
`ifdef STOPWATCH_LAP_EN
                        hold_q      <= 1'b0;
`endif
                    end
`ifdef STOPWATCH_LAP_EN
                    // Lap in STOPPED can only release a frozen display.
                    else if (lap_ev) begin
                        hold_q <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q   <= CLEARED;
                    div_res_q <= 1'b0;
`ifdef STOPWATCH_LAP_EN
                    hold_q    <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign state     = state_q;
    assign div_res   = div_res_q;
    assign count_en  = count_en_q;
    assign count_clr = count_clr_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// tb/tb_stopwatch_controller.sv - self-checking bench for stopwatch_controller
`timescale 1ns/1ps

module tb_stopwatch_controller;
    localparam int DB = 20;
    localparam int DW = 5;
    localparam int H  = 25;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP = 1'b1;
`else
    localparam bit LAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       b_ss = 1'b0;
    logic       b_lap = 1'b0;
    logic       b_clr = 1'b0;
    logic       tick = 1'b0;
    logic       div_res;
    logic       count_en;
    logic       count_clr;
    logic       display_hold;
    logic [1:0] state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int clr_cnt = 0;
    int dcnt = 0;

    stopwatch_controller #(.DEBOUNCE_CYCLES(DB), .DB_WIDTH(DW)) dut (
        .clk_in        (clk),
        .res           (res),
        .btn_start_stop(b_ss),
        .btn_lap       (b_lap),
        .btn_clear     (b_clr),
        .tick_in       (tick),
        .div_res       (div_res),
        .count_en      (count_en),
        .count_clr     (count_clr),
        .display_hold  (display_hold),
        .state         (state)
    );

    always #500 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: held at 0 while div_res is low, toggles every H cycles.
    always @(posedge clk) begin
        if (!div_res) begin
            dcnt <= 0;
            tick <= 1'b0;
        end else if (dcnt == H - 1) begin
            dcnt <= 0;
            tick <= ~tick;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    always @(negedge clk) begin
        if (count_en) en_cnt = en_cnt + 1;
        if (count_clr) clr_cnt = clr_cnt + 1;
    end

    typedef struct {
        logic       ss;
        logic       lap;
        logic       clr;
        logic [1:0] st;
        logic       hold;
        int         clrs;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total = total + 1;
        if (act < lo || act > hi) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic ss, input logic lap, input logic clr);
        b_ss = ss; b_lap = lap; b_clr = clr;
        step(DB + 8);
        b_ss = 1'b0; b_lap = 1'b0; b_clr = 1'b0;
        step(DB + 8);
    endtask

    initial begin
        int c0;
        int ct;
        int p;
        bit found;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 0};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 2'b10, 1'b1, 0};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1};

        // Reset state
        step(3);
        check("rst_state", state, 0);
        check("rst_div_res", div_res, 0);
        check("rst_count_en", count_en, 0);
        check("rst_count_clr", count_clr, 0);
        check("rst_hold", display_hold, 0);
        res = 1'b1;
        en_cnt = 0;
        clr_cnt = 0;
        step(2000);
        check("idle_state", state, 0);
        check("idle_div_res", div_res, 0);
        check("idle_en_pulses", en_cnt, 0);
        check("idle_clr_pulses", clr_cnt, 0);

        // Bouncing start press, then held
        c0 = 0;
        for (int i = 0; i < 3; i++) begin
            b_ss = 1'b1;
            c0 = cyc;
            step(5);
            b_ss = 1'b0;
            step(5);
        end
        b_ss = 1'b1;
        c0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (state == 2'b01) found = 1'b1;
        end
        check("start_seen", found, 1);
        ct = cyc;
        check_range("start_latency", ct - c0, DB + 1, DB + 5);
        check("start_div_res", div_res, 1);

        found = 1'b0;
        for (int i = 0; i < 4 * H && !found; i++) begin
            step(1);
            if (count_en) found = 1'b1;
        end
        check("first_en_seen", found, 1);
        check_range("first_en_gap", cyc - ct, 2 * H - 3, 2 * H + 3);
        p = cyc;
        found = 1'b0;
        for (int i = 0; i < 4 * H && !found; i++) begin
            step(1);
            if (count_en) found = 1'b1;
        end
        check("second_en_gap", cyc - p, 2 * H);
        b_ss = 1'b0;

        // Run 20 tick periods
        step(1);
        en_cnt = 0;
        step(41 * H);
        check("run_pulses", en_cnt, 20);

        // Stop: no further count_en
        press(1'b1, 1'b0, 1'b0);
        check("stop_state", state, 2);
        en_cnt = 0;
        step(6 * H);
        check("stop_no_en", en_cnt, 0);
        check("stop_div_res", div_res, 1);

        // Restart: pulses resume within one tick period
        b_ss = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step(1);
            if (state == 2'b01) found = 1'b1;
        end
        check("restart_seen", found, 1);
        found = 1'b0;
        for (int i = 0; i < 2 * H + 4 && !found; i++) begin
            step(1);
            if (count_en) found = 1'b1;
        end
        check("restart_en_seen", found, 1);
        b_ss = 1'b0;
        step(DB + 8);

        // Lap while running, then asynchronous reset mid-run
        press(1'b0, 1'b1, 1'b0);
        check("lap_hold", display_hold, int'(LAP));
        en_cnt = 0;
        step(4 * H);
        check("lap_en_continues", en_cnt > 0, 1);
        res = 1'b0;
        #5;
        check("arst_state", state, 0);
        check("arst_div_res", div_res, 0);
        check("arst_count_en", count_en, 0);
        check("arst_count_clr", count_clr, 0);
        check("arst_hold", display_hold, 0);
        step(1);
        res = 1'b1;
        en_cnt = 0;
        step(6 * H);
        check("post_rst_state", state, 0);
        check("post_rst_en", en_cnt, 0);
        check("post_rst_div_res", div_res, 0);

        // Table of button presses from CLEARED
        clr_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            press(vecs[i].ss, vecs[i].lap, vecs[i].clr);
            check($sformatf("vec%0d_state", i), state, vecs[i].st);
            check($sformatf("vec%0d_hold", i), display_hold, int'(vecs[i].hold & LAP));
            check($sformatf("vec%0d_div_res", i), div_res, int'(vecs[i].st != 2'b00));
            check($sformatf("vec%0d_clr_pulses", i), clr_cnt, vecs[i].clrs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Run-control sequencer for the stopwatch datapath.
- Takes the three user buttons and the 100 Hz divider output. Debounces the buttons and runs the start/stop/lap/clear state machine.
- Holds the clock divider in reset while the stopwatch is cleared.
- Issues one-cycle count enables and clear pulses to the time counters, and a display-hold flag for lap freeze.
- Sits between the IO pins, clockDivider and the BCD time counters. Runs on the 1 MHz system clock.

Parameters:
- DEBOUNCE_CYCLES, 10000, consecutive stable clk_in cycles before a button change is accepted (10 ms at 1 MHz).
- DB_WIDTH, 14, debounce counter width; must satisfy 2^DB_WIDTH > DEBOUNCE_CYCLES.

Ports:
- clk_in  input  1  system clock, 1 MHz
- res  input  1  reset; asynchronous, active-low
- btn_start_stop  input  1  raw button, active-high, asynchronous to clk_in
- btn_lap  input  1  raw button, active-high, asynchronous
- btn_clear  input  1  raw button, active-high, asynchronous
- tick_in  input  1  100 Hz square wave from the divider; registered in the clk_in domain
- div_res  output  1  active-low reset to clockDivider
- count_en  output  1  one-cycle enable to the time counters, one per 10 ms while running
- count_clr  output  1  one-cycle synchronous clear to the time counters
- display_hold  output  1  1 = display latches frozen (lap)
- state  output  2  00 CLEARED, 01 RUNNING, 10 STOPPED

Behaviour:
- Reset (res=0, asynchronous): state=CLEARED, div_res=0, count_en=0, count_clr=0, display_hold=0. All synchronizer, debounce and edge registers clear to 0. Reset asserted mid-operation returns everything to these values immediately.
- Button path, per button:
  - 2-FF synchronizer feeds the debouncer.
  - The debounced level updates only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles. Any return to the old value restarts the count at 0.
  - A press event is a one-cycle pulse on the debounced rising edge. Releases generate nothing. Holding a button produces exactly one event.
- Tick path: tick_in is registered once. The tick event is its falling edge (1 to 0), i.e. one event per full 10 ms period. The first event comes 10 ms after div_res releases.
- All outputs are registered; each reacts one cycle after the causing event.
- State transitions. Simultaneous-event priority: start_stop > clear > lap.
  - CLEARED:
    - start_stop -> RUNNING.
    - clear and lap are ignored.
    - div_res=0 in this state only.
  - RUNNING:
    - Each tick event -> count_en=1 for one cycle.
    - start_stop -> STOPPED. A tick event in the same cycle still produces its count_en.
    - lap toggles display_hold.
    - clear is ignored.
  - STOPPED:
    - count_en stays 0; the divider keeps running.
    - start_stop -> RUNNING; display_hold is unchanged.
    - clear -> CLEARED with count_clr=1 for one cycle and display_hold=0.
    - lap: if display_hold=1, clear it; otherwise ignored.
- Leaving CLEARED: div_res goes to 1 in the same cycle that state becomes RUNNING.
- Ticks while not RUNNING are discarded; they are not queued.
- Encoding 11 is unreachable. If it is entered, the next state is CLEARED.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined: btn_lap path and display_hold behave as described above.
- Undefined:
  - The lap synchronizer and debouncer are not built.
  - btn_lap is ignored.
  - display_hold is constant 0.
  - All other behaviour is identical.

Test Plan:
- Reset then idle 50000 cycles -> state=00, div_res=0, count_en never 1, count_clr=0, display_hold=0.
- Start/stop debounce:
  - btn_start_stop bounces (three 100-cycle pulses), then held high 12000 cycles -> exactly one transition to RUNNING, about 10002 cycles after the last rising bounce.
  - div_res=1 from that cycle.
  - First count_en 10000 (±3) cycles later, then every 10000 cycles.
- Run 1 s -> exactly 100 count_en pulses.
- Stop press -> state=10, no further count_en.
- Second start -> pulses resume at the next tick falling edge.
- In STOPPED, start_stop and clear debounced events in the same cycle -> state=01, count_clr stays 0.
- In STOPPED, clear alone -> state=00, one count_clr pulse, div_res=0.
- With STOPWATCH_LAP_EN:
  - lap in RUNNING -> display_hold=1 while count_en continues.
  - Second lap -> display_hold=0.
  - lap, stop, lap -> display_hold=0.
  - Without the macro, the same lap presses leave display_hold=0.
- Assert res for 1 µs mid-RUNNING with display_hold=1 -> all outputs at reset values immediately; after release state=00 and no count_en.
